// File: rtl/cache_pkg.sv
// Shared types and constants for the write-back cache controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cache_pkg;

  localparam int XLEN       = 32;  // address/data width
  localparam int C_WIDTH    = 13;  // array index+offset bits (8 KiB)
  localparam int LINE_BYTES = 4;   // one word per line

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    FILL
  } ctrl_state_t;

  // Clear the byte offset so memory sees a line-aligned word address.
  function automatic logic [XLEN-1:0] line_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/cache_ctrl_if.sv
// CPU, cache-array and memory signal bundle of the cache controller.
// Latency: n/a (wiring only).
// Backpressure: cpu_req held until cpu_ready; mem_req held until mem_ack.
interface cache_ctrl_if;
  import cache_pkg::*;

  // CPU load/store port
  logic            cpu_req;
  logic            cpu_we;
  logic [XLEN-1:0] cpu_addr;
  logic [XLEN-1:0] cpu_wdata;
  logic [XLEN-1:0] cpu_rdata;
  logic            cpu_ready;

  // Direct-mapped cache array
  logic [XLEN-1:0] cache_addr;
  logic            cache_we;
  logic [XLEN-1:0] cache_wdata;
  logic [XLEN-1:0] cache_rdata;
  logic            cache_hit;
  logic            cache_dirty;
  logic [XLEN-1:0] cache_miss_addr;

  // Main memory
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_ack;

  // Controller side
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready,
    output cache_addr, cache_we, cache_wdata,
    input  cache_rdata, cache_hit, cache_dirty, cache_miss_addr,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  // CPU / array / memory side
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready,
    input  cache_addr, cache_we, cache_wdata,
    output cache_rdata, cache_hit, cache_dirty, cache_miss_addr,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/cache_ctrl_stats.sv
// Saturating hit/miss/writeback event counters (built with CACHE_CTRL_STATS_EN).
// Latency: count visible the cycle after the event.
// Backpressure: none; counters hold at all-ones instead of wrapping.
`ifdef CACHE_CTRL_STATS_EN
module cache_ctrl_stats (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        hit_ev,
  input  logic        miss_ev,
  input  logic        wb_ev,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
  output logic [31:0] wb_cnt
);

  // Count each event once per cycle, sticking at the maximum value.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (hit_ev  && (hit_cnt  != '1)) hit_cnt  <= hit_cnt  + 32'd1;
      if (miss_ev && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
      if (wb_ev   && (wb_cnt   != '1)) wb_cnt   <= wb_cnt   + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/cache_ctrl.sv
// Write-back controller for a direct-mapped single-word-line cache; optional
// statistics counters are enabled by defining CACHE_CTRL_STATS_EN.
// Latency: hit completes 1 cycle after request; miss adds writeback, fetch and fill.
// Backpressure: CPU stalled via cpu_ready; memory request held until mem_ack.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic         clk,
  input  logic         rst_b,
  cache_ctrl_if.master bus
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [31:0]  hit_cnt,
  output logic [31:0]  miss_cnt,
  output logic [31:0]  wb_cnt
`endif
);

  ctrl_state_t     state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic            we_q;
  logic [XLEN-1:0] fill_q;
  logic            mem_req_q;
  logic            mem_we_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic            hit_now;

  // Request tracking and miss handling; memory-side outputs are registered.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      fill_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (bus.cache_hit) begin
            state <= IDLE;
          end else if (bus.cache_dirty) begin
            // Capture the victim while the array still presents it.
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= bus.cache_miss_addr;
            mem_wdata_q <= bus.cache_rdata;
            state       <= WRITEBACK;
          end else begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= line_align(addr_q);
            state      <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          // Request stays high straight into the fetch.
          if (bus.mem_ack) begin
            mem_we_q   <= 1'b0;
            mem_addr_q <= line_align(addr_q);
            state      <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack) begin
            fill_q    <= bus.mem_rdata;
            mem_req_q <= 1'b0;
            state     <= FILL;
          end
        end
        FILL: begin
          state <= COMPARE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign hit_now        = (state == COMPARE) && bus.cache_hit;
  assign bus.cache_addr = addr_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

  // CPU completion and array writes follow the array's same-cycle hit.
  always_comb begin
    bus.cpu_ready   = 1'b0;
    bus.cpu_rdata   = '0;
    bus.cache_we    = 1'b0;
    bus.cache_wdata = '0;
    if (hit_now) begin
      bus.cpu_ready = 1'b1;
      bus.cpu_rdata = bus.cache_rdata;
      if (we_q) begin
        bus.cache_we    = 1'b1;
        bus.cache_wdata = wdata_q;
      end
    end else if (state == FILL) begin
      bus.cache_we    = 1'b1;
      bus.cache_wdata = fill_q;
    end
  end

`ifdef CACHE_CTRL_STATS_EN
  logic retry_q;

  // Marks the COMPARE following a FILL so it is not counted twice.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      retry_q <= 1'b0;
    end else if (state == FILL) begin
      retry_q <= 1'b1;
    end else if (state == IDLE) begin
      retry_q <= 1'b0;
    end
  end

  cache_ctrl_stats u_stats (
    .clk      (clk),
    .rst_b    (rst_b),
    .hit_ev   (hit_now && !retry_q),
    .miss_ev  ((state == COMPARE) && !bus.cache_hit && !retry_q),
    .wb_ev    ((state == WRITEBACK) && bus.mem_ack),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
  );
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural cache array and memory.
// Latency: n/a.
// Backpressure: memory acks after a programmable number of request cycles.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int IDX_W = C_WIDTH - 2;
  localparam int TAG_W = XLEN - C_WIDTH;
  localparam int NLINE = 2 ** IDX_W;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  cache_ctrl_if bus();

`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_ctrl dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
`ifdef CACHE_CTRL_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- cache array model ----------------
  logic [XLEN-1:0]  data_m  [NLINE];
  logic [TAG_W-1:0] tag_m   [NLINE];
  logic             valid_m [NLINE];
  logic             dirty_m [NLINE];
  logic             clr_model;
  logic             pl_en;
  logic             pl_dirty;
  logic [XLEN-1:0]  pl_addr;
  logic [XLEN-1:0]  pl_data;

  wire [IDX_W-1:0] cidx  = bus.cache_addr[C_WIDTH-1:2];
  wire [TAG_W-1:0] ctag  = bus.cache_addr[XLEN-1:C_WIDTH];
  wire [IDX_W-1:0] plidx = pl_addr[C_WIDTH-1:2];

  assign bus.cache_hit       = valid_m[cidx] && (tag_m[cidx] == ctag);
  assign bus.cache_dirty     = valid_m[cidx] && dirty_m[cidx];
  assign bus.cache_rdata     = data_m[cidx];
  assign bus.cache_miss_addr = {tag_m[cidx], cidx, 2'b00};

  // Array storage: a write to an already-hitting line is a store (dirty), else a fill (clean).
  always @(posedge clk) begin
    if (clr_model) begin
      for (int i = 0; i < NLINE; i++) begin
        valid_m[i] <= 1'b0;
        dirty_m[i] <= 1'b0;
        tag_m[i]   <= '0;
        data_m[i]  <= '0;
      end
    end else if (pl_en) begin
      data_m[plidx]  <= pl_data;
      tag_m[plidx]   <= pl_addr[XLEN-1:C_WIDTH];
      valid_m[plidx] <= 1'b1;
      dirty_m[plidx] <= pl_dirty;
    end else if (bus.cache_we) begin
      data_m[cidx]  <= bus.cache_wdata;
      tag_m[cidx]   <= ctag;
      valid_m[cidx] <= 1'b1;
      dirty_m[cidx] <= bus.cache_hit;
    end
  end

  // ---------------- memory model + monitor ----------------
  int              wb_lat = 1, fetch_lat = 1;
  logic [XLEN-1:0] fetch_data = '0;
  int              mcnt = 0;
  int              we_cnt = 0, memreq_cnt = 0, dbl_ready = 0, wb_seen = 0, fetch_seen = 0;
  logic            prev_ready = 1'b0;
  logic [XLEN-1:0] wb_addr = '0, wb_data = '0, fetch_addr = '0, store_wdata = '0;

  // Observe outputs mid-cycle, then drive the ack for the next edge.
  always @(negedge clk) begin
    if (bus.cache_we) we_cnt++;
    if (bus.mem_req) memreq_cnt++;
    if (bus.cpu_ready && prev_ready) dbl_ready++;
    prev_ready = bus.cpu_ready;
    if (bus.cache_we && bus.cpu_ready) store_wdata = bus.cache_wdata;
    if (bus.mem_req) begin
      if (bus.mem_ack) mcnt = 0;
      mcnt++;
      if (mcnt == (bus.mem_we ? wb_lat : fetch_lat)) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = bus.mem_we ? '0 : fetch_data;
        if (bus.mem_we) begin
          wb_seen++;
          wb_addr = bus.mem_addr;
          wb_data = bus.mem_wdata;
        end else begin
          fetch_seen++;
          fetch_addr = bus.mem_addr;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
    end else begin
      mcnt        = 0;
      bus.mem_ack = 1'b0;
    end
  end

  // ---------------- helpers (stimulus only) ----------------
  int s_we, s_mr, s_wb, s_fe;

  task automatic preload(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic dirty);
    pl_addr = a; pl_data = d; pl_dirty = dirty; pl_en = 1'b1;
    @(posedge clk); #1 pl_en = 1'b0;
    @(negedge clk);
  endtask

  // Issue one request at a negedge; lat is the completion cycle (-1 on timeout).
  task automatic do_req(input logic we, input logic [XLEN-1:0] a, input logic [XLEN-1:0] wd,
                        output int lat, output logic [XLEN-1:0] rd);
    s_we = we_cnt; s_mr = memreq_cnt; s_wb = wb_seen; s_fe = fetch_seen;
    bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
    @(posedge clk);
    lat = -1; rd = '0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (bus.cpu_ready) begin
        lat = n; rd = bus.cpu_rdata;
        break;
      end
    end
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_b = 1'b1; clr_model = 1'b1; pl_en = 1'b0; pl_dirty = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
    n_chk++; if ({bus.cpu_ready, bus.cpu_rdata} !== 33'h0) begin n_fail++; $display("FAIL reset_cpu_out: ready=%b rdata=%h expected 0", bus.cpu_ready, bus.cpu_rdata); end
    n_chk++; if ({bus.cache_we, bus.cache_wdata, bus.cache_addr} !== 65'h0) begin n_fail++; $display("FAIL reset_cache_out: we=%b wdata=%h addr=%h expected 0", bus.cache_we, bus.cache_wdata, bus.cache_addr); end
    n_chk++; if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 66'h0) begin n_fail++; $display("FAIL reset_mem_out: req=%b we=%b addr=%h wdata=%h expected 0", bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    rst_b = 1'b0; clr_model = 1'b0;
    @(negedge clk);
    n_chk++; if ({bus.cpu_ready, bus.mem_req, bus.cache_we} !== 3'b000) begin n_fail++; $display("FAIL idle_quiet: ready/mem_req/cache_we=%b expected 000", {bus.cpu_ready, bus.mem_req, bus.cache_we}); end
  endtask

  task automatic test_read_hit;
    int lat; logic [XLEN-1:0] rd;
    preload(32'h0000_0040, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 32'h0000_0040, '0, lat, rd);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", lat); end
    n_chk++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hit_rdata: got %h expected deadbeef", rd); end
    n_chk++; if (memreq_cnt - s_mr !== 0) begin n_fail++; $display("FAIL hit_no_mem: got %0d mem_req cycles expected 0", memreq_cnt - s_mr); end
    n_chk++; if (we_cnt - s_we !== 0) begin n_fail++; $display("FAIL hit_no_write: got %0d cache_we expected 0", we_cnt - s_we); end
  endtask

  task automatic test_clean_miss;
    int lat; logic [XLEN-1:0] rd;
    fetch_lat = 3; fetch_data = 32'h12345678;
    do_req(1'b0, 32'h0001_2000, '0, lat, rd);
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL clean_miss_latency: got %0d expected 6", lat); end
    n_chk++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL clean_miss_rdata: got %h expected 12345678", rd); end
    n_chk++; if (we_cnt - s_we !== 1) begin n_fail++; $display("FAIL clean_miss_we: got %0d pulses expected 1", we_cnt - s_we); end
    n_chk++; if (wb_seen - s_wb !== 0) begin n_fail++; $display("FAIL clean_miss_no_wb: got %0d expected 0", wb_seen - s_wb); end
    n_chk++; if (fetch_addr !== 32'h0001_2000) begin n_fail++; $display("FAIL clean_miss_addr: got %h expected 00012000", fetch_addr); end
  endtask

  task automatic test_dirty_write_miss;
    int lat; logic [XLEN-1:0] rd;
    preload(32'h0000_A400, 32'hAAAA5555, 1'b1);
    wb_lat = 2; fetch_lat = 1; fetch_data = 32'h0BADC0DE;
    do_req(1'b1, 32'h0000_E400, 32'hCAFEF00D, lat, rd);
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL dirty_miss_latency: got %0d expected 6", lat); end
    n_chk++; if (wb_addr !== 32'h0000_A400) begin n_fail++; $display("FAIL dirty_wb_addr: got %h expected 0000a400", wb_addr); end
    n_chk++; if (wb_data !== 32'hAAAA5555) begin n_fail++; $display("FAIL dirty_wb_data: got %h expected aaaa5555", wb_data); end
    n_chk++; if (fetch_addr !== 32'h0000_E400) begin n_fail++; $display("FAIL dirty_fetch_addr: got %h expected 0000e400", fetch_addr); end
    n_chk++; if (we_cnt - s_we !== 2) begin n_fail++; $display("FAIL dirty_we_count: got %0d expected 2", we_cnt - s_we); end
    n_chk++; if (store_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL dirty_store_wdata: got %h expected cafef00d", store_wdata); end
    n_chk++; if (rd !== 32'h0BADC0DE) begin n_fail++; $display("FAIL dirty_store_rdata: got %h expected 0badc0de", rd); end
  endtask

  task automatic test_store_hit;
    int lat; logic [XLEN-1:0] rd;
    preload(32'h0000_0080, 32'h0, 1'b0);
    do_req(1'b1, 32'h0000_0080, 32'h11223344, lat, rd);
    n_chk++; if (lat !== 1) begin n_fail++; $display("FAIL store_hit_latency: got %0d expected 1", lat); end
    n_chk++; if (we_cnt - s_we !== 1) begin n_fail++; $display("FAIL store_hit_we: got %0d pulses expected 1", we_cnt - s_we); end
    n_chk++; if (store_wdata !== 32'h11223344) begin n_fail++; $display("FAIL store_hit_wdata: got %h expected 11223344", store_wdata); end
    n_chk++; if (memreq_cnt - s_mr !== 0) begin n_fail++; $display("FAIL store_hit_no_mem: got %0d expected 0", memreq_cnt - s_mr); end
  endtask

  task automatic test_reset_mid_wb;
    int lat; logic [XLEN-1:0] rd; logic found;
    preload(32'h0000_6800, 32'h5A5A5A5A, 1'b1);
    wb_lat = 20; fetch_lat = 2;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_8800;
    @(posedge clk);
    found = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.mem_req) begin found = 1'b1; break; end
    end
    n_chk++; if ({found, bus.mem_we} !== 2'b11) begin n_fail++; $display("FAIL rst_wb_entered: found=%b mem_we=%b expected 1 1", found, bus.mem_we); end
    rst_b = 1'b1; bus.cpu_req = 1'b0; bus.cpu_addr = '0;
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    n_chk++; if (dut.state !== IDLE) begin n_fail++; $display("FAIL rst_state: got %0d expected %0d", dut.state, IDLE); end
    n_chk++; if (bus.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_ready: got %b expected 0", bus.cpu_ready); end
    rst_b = 1'b0;
    @(negedge clk);
    wb_lat = 1; fetch_data = 32'h77778888;
    do_req(1'b0, 32'h0000_8800, '0, lat, rd);
    n_chk++; if (lat !== 6) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 6", lat); end
    n_chk++; if (rd !== 32'h77778888) begin n_fail++; $display("FAIL post_rst_rdata: got %h expected 77778888", rd); end
    n_chk++; if ({wb_addr, wb_data} !== {32'h0000_6800, 32'h5A5A5A5A}) begin n_fail++; $display("FAIL post_rst_wb: addr=%h data=%h expected 00006800 5a5a5a5a", wb_addr, wb_data); end
  endtask

`ifdef CACHE_CTRL_STATS_EN
  task automatic test_stats;
    int lat; logic [XLEN-1:0] rd;
    rst_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    n_chk++; if ({hit_cnt, miss_cnt, wb_cnt} !== 96'h0) begin n_fail++; $display("FAIL stats_reset: %0d %0d %0d expected 0 0 0", hit_cnt, miss_cnt, wb_cnt); end
    wb_lat = 1; fetch_lat = 1; fetch_data = 32'h0000_00F0;
    do_req(1'b0, 32'h0000_0040, '0, lat, rd);
    do_req(1'b0, 32'h0000_0100, '0, lat, rd);
    do_req(1'b0, 32'h0000_2080, '0, lat, rd);
    n_chk++; if (hit_cnt !== 32'd1) begin n_fail++; $display("FAIL stats_hit: got %0d expected 1", hit_cnt); end
    n_chk++; if (miss_cnt !== 32'd2) begin n_fail++; $display("FAIL stats_miss: got %0d expected 2", miss_cnt); end
    n_chk++; if (wb_cnt !== 32'd1) begin n_fail++; $display("FAIL stats_wb: got %0d expected 1", wb_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_hit();
    test_clean_miss();
    test_dirty_write_miss();
    test_store_hit();
    test_reset_mid_wb();
`ifdef CACHE_CTRL_STATS_EN
    test_stats();
`endif
    n_chk++; if (dbl_ready !== 0) begin n_fail++; $display("FAIL ready_pulse: got %0d back-to-back cpu_ready cycles expected 0", dbl_ready); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Single-word-line, write-back cache controller between the CPU load/store port and the direct-mapped 8 KiB cache array.
- On a hit, returns or updates data.
- On a miss, writes back the dirty victim to main memory, fetches the missing line, fills the array, then retries.
- Drives all array and memory handshakes; stalls the CPU via cpu_ready.

Parameters:
- XLEN, 32, address/data width.
- C_WIDTH, 13, cache index+offset bits, matching the array's address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset; synchronous, active-high (asserted = 1).
- cpu_req  in  1  request valid; held until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  XLEN  byte address, word aligned.
- cpu_wdata  in  XLEN  store data.
- cpu_rdata  out  XLEN  load data; valid when cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- cache_addr  out  XLEN  array address (latched request address).
- cache_we  out  1  array write strobe.
- cache_wdata  out  XLEN  array write data; byte i = bits [8i+7:8i].
- cache_rdata  in  XLEN  array read data, same byte order.
- cache_hit  in  1  array hit.
- cache_dirty  in  1  indexed line dirty.
- cache_miss_addr  in  XLEN  victim line address.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  1 = writeback, 0 = fetch.
- mem_addr  out  XLEN  memory word address.
- mem_wdata  out  XLEN  writeback data.
- mem_rdata  in  XLEN  fetch data; valid with mem_ack.
- mem_ack  in  1  one-cycle completion from memory.

Behaviour:
- States:
  - IDLE
  - COMPARE
  - WRITEBACK
  - ALLOCATE
  - FILL
- Reset:
  - State goes to IDLE.
  - All outputs are 0, and the latched addr/we/wdata are 0.
  - Reset mid-transaction abandons the transaction; mem_req drops the cycle after reset is sampled.
- IDLE:
  - When cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata, then go to COMPARE.
  - CPU inputs are ignored in every other state.
- COMPARE:
  - cache_addr = latched address.
  - If cache_hit=1:
    - cpu_ready=1 and cpu_rdata=cache_rdata.
    - On a store, also cache_we=1 and cache_wdata=latched wdata.
    - Go to IDLE.
  - Else if cache_dirty=1: go to WRITEBACK.
  - Else: go to ALLOCATE.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr=cache_miss_addr (registered on entry).
  - mem_wdata=cache_rdata (registered on entry).
  - On mem_ack, go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0.
  - mem_addr={addr[31:2],2'b00}.
  - On mem_ack, register mem_rdata and go to FILL.
- FILL:
  - cache_we=1, cache_wdata=registered fetch data.
  - Go to COMPARE; the retry hits.
- Latency, with request sampled at cycle 0:
  - Hit: cpu_ready at cycle 1.
  - Clean miss with mem_ack in the k-th ALLOCATE cycle: cpu_ready at cycle k+3.
  - Dirty miss adds the WRITEBACK cycles.
- mem_ack seen outside WRITEBACK or ALLOCATE is ignored.
- cpu_ready is never high in two consecutive cycles.

Optional Feature:
- CACHE_CTRL_STATS_EN defined:
  - Adds outputs hit_cnt, miss_cnt and wb_cnt, each 32 bits.
  - hit_cnt increments on the first COMPARE of a request if hit.
  - miss_cnt increments on entry to the WRITEBACK or ALLOCATE path.
  - wb_cnt increments on the WRITEBACK ack.
  - Counters saturate at 0xFFFFFFFF and clear on reset.
  - A retry COMPARE after FILL is not counted.
- Undefined: the ports and counter logic are absent.

Decomposition:
- cache_pkg holds:
  - ctrl_state_t enum {IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL}.
  - Constants XLEN, C_WIDTH, LINE_BYTES=4.
- No sub-module, except optional cache_ctrl_stats (counter bank) when CACHE_CTRL_STATS_EN is defined.

Test Plan:
- Read hit:
  - Preload 0x0000_0040 = 0xDEADBEEF, then load 0x40.
  - Expect cpu_ready at cycle 1, cpu_rdata=0xDEADBEEF, no mem_req.
- Clean read miss:
  - Load 0x0001_2000 with memory returning 0x12345678 and ack on the 3rd ALLOCATE cycle.
  - Expect cpu_ready at cycle 6, cpu_rdata=0x12345678, exactly one cache_we pulse.
- Dirty write miss:
  - Line holds dirty 0xAAAA5555 at tag A; store 0xCAFEF00D to tag B, same index.
  - Expect a WRITEBACK with mem_addr=cache_miss_addr and mem_wdata=0xAAAA5555, then a fetch, FILL, and a store hit with cache_wdata=0xCAFEF00D.
- Store hit:
  - Store 0x11223344 to a resident line.
  - Expect cache_we=1 for one cycle at cycle 1, cpu_ready=1, no memory traffic.
- Reset mid-WRITEBACK:
  - Assert rst_b for one cycle while mem_req=1.
  - Expect next cycle: mem_req=0, state IDLE, cpu_ready=0; a following request completes normally.
- Stats (CACHE_CTRL_STATS_EN):
  - Sequence: hit, clean miss, dirty miss.
  - Expect hit_cnt=1, miss_cnt=2, wb_cnt=1.
